uart_rx_buffer: RTL and testbench

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

---
 rtl/uart_rx_buffer_pkg.sv | 9 +
 rtl/uart_rx_buffer_mem.sv | 37 +++
 rtl/uart_rx_buffer.sv | 123 ++++++++++++
 tb/tb_uart_rx_buffer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_buffer_pkg.sv
// Shared types and defaults for the UART receive buffer slice.
package uart_rx_buffer_pkg;

  typedef logic       Bit_t;
  typedef logic [7:0] Byte_t;

  localparam int unsigned UART_RX_DEPTH = 16;

endpackage : uart_rx_buffer_pkg

// File: rtl/uart_rx_buffer_mem.sv
// Byte storage for the receive FIFO: one synchronous write port, one
// synchronous read port with enable, no reset on the array or read register.
module uart_fifo_mem
  import uart_rx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = UART_RX_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  Byte_t         wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output Byte_t         rdata
);

  Byte_t mem_q [DEPTH];
  Byte_t rdata_q;

  // Write port: store the incoming byte at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: registered read; holds its value when not enabled.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule : uart_fifo_mem

// File: rtl/uart_rx_buffer.sv
// Receive-side byte FIFO between a serial controller and the CPU. Tracks
// occupancy, drops bytes arriving while full (sticky overflow) and throttles
// the controller through read_op when free space falls below a reserve.
module uart_rx_buffer
  import uart_rx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH    = UART_RX_DEPTH,
  parameter int unsigned HEADROOM = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   read_op,
  input  logic                   pop,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] RO_LIMIT = CW'(DEPTH - HEADROOM);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  logic          rd_valid_q, rd_valid_d;
  logic          read_op_q, read_op_d;
  logic          rd_seen_q, rd_seen_d;
  logic          push_ok, pop_ok, drop;
  Byte_t         mem_rdata;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (rx_data),
    .re    (pop_ok),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // Next-state for pointers, occupancy, flags and flow control.
  always_comb begin
    pop_ok  = pop && !empty_q;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok = rx_valid && (!full_q || pop_ok);
    drop    = rx_valid && full_q && !pop_ok;

    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);

    // A new drop wins over a simultaneous clear.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end

    rd_valid_d = pop_ok;
    // The storage read register has no reset; rd_data reads as zero until
    // the first accepted pop after reset has loaded it.
    rd_seen_d  = rd_seen_q || pop_ok;
    read_op_d  = (count_q < RO_LIMIT);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      read_op_q  <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      read_op_q  <= read_op_d;
      rd_seen_q  <= rd_seen_d;
    end
  end

  assign rd_data  = rd_seen_q ? mem_rdata : '0;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign read_op  = read_op_q;

endmodule : uart_rx_buffer

// File: tb/tb_uart_rx_buffer.sv
// Directed self-checking bench for uart_rx_buffer (DEPTH=16, HEADROOM=1).
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       read_op;
  logic       pop;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       clr_overflow;

  int checks   = 0;
  int failures = 0;

  uart_rx_buffer #(
    .DEPTH    (16),
    .HEADROOM (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .read_op      (read_op),
    .pop          (pop),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] v);
    rx_valid = 1'b1;
    rx_data  = v;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_rdv"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rdd"}, 32'(rd_data), 32'h00);
    chk({tag, "_rop"}, 32'(read_op), 32'd0);
  endtask

  initial begin
    int occ;
    int pushed;
    int popped;
    logic up;
    logic do_push;
    logic do_pop;

    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; pop = 1'b0; clr_overflow = 1'b0;

    // Reset values, then release between edges.
    cyc(); cyc();
    chk_reset_outputs("rst");
    rst = 1'b1;
    cyc();
    chk("rel_rop", 32'(read_op), 32'd1);
    chk("rel_empty", 32'(empty), 32'd1);

    // Three bytes in, three pops out with latency 1.
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    chk("abc_count", 32'(count), 32'd3);
    chk("abc_empty", 32'(empty), 32'd0);
    pop = 1'b1;
    cyc(); chk("abc_v0", 32'(rd_valid), 32'd1); chk("abc_d0", 32'(rd_data), 32'h41);
    cyc(); chk("abc_v1", 32'(rd_valid), 32'd1); chk("abc_d1", 32'(rd_data), 32'h42);
    cyc(); chk("abc_v2", 32'(rd_valid), 32'd1); chk("abc_d2", 32'(rd_data), 32'h43);
    pop = 1'b0;
    cyc();
    chk("abc_idle_v", 32'(rd_valid), 32'd0);
    chk("abc_hold_d", 32'(rd_data), 32'h43);
    chk("abc_empty_after", 32'(empty), 32'd1);

    // Fill with 00..0F, then drop 10.
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i));
      if (i == 14) chk("fill15_rop_lag", 32'(read_op), 32'd1);
      if (i == 14) chk("fill15_full", 32'(full), 32'd0);
    end
    chk("fill16_full", 32'(full), 32'd1);
    chk("fill16_count", 32'(count), 32'd16);
    chk("fill16_rop", 32'(read_op), 32'd0);
    chk("fill16_ovf", 32'(overflow), 32'd0);
    push_byte(8'h10);
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_count", 32'(count), 32'd16);

    // Clear colliding with a new drop loses; a lone clear wins.
    rx_valid = 1'b1; rx_data = 8'hEE; clr_overflow = 1'b1;
    cyc();
    rx_valid = 1'b0;
    chk("clr_vs_drop", 32'(overflow), 32'd1);
    cyc();
    clr_overflow = 1'b0;
    chk("clr_alone", 32'(overflow), 32'd0);

    // Full plus simultaneous push AA and pop.
    rx_valid = 1'b1; rx_data = 8'hAA; pop = 1'b1;
    cyc();
    rx_valid = 1'b0;
    chk("fullpp_count", 32'(count), 32'd16);
    chk("fullpp_ovf", 32'(overflow), 32'd0);
    chk("fullpp_v", 32'(rd_valid), 32'd1);
    chk("fullpp_d", 32'(rd_data), 32'h00);
    for (int i = 1; i < 16; i++) begin
      cyc();
      chk("drain_d", 32'(rd_data), 32'(i));
      chk("drain_v", 32'(rd_valid), 32'd1);
    end
    cyc();
    chk("drain_aa", 32'(rd_data), 32'hAA);
    pop = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    cyc();
    chk("drain_rop", 32'(read_op), 32'd1);

    // Empty plus simultaneous push 55 and pop: pop ignored.
    rx_valid = 1'b1; rx_data = 8'h55; pop = 1'b1;
    cyc();
    rx_valid = 1'b0; pop = 1'b0;
    chk("emptypp_v", 32'(rd_valid), 32'd0);
    chk("emptypp_count", 32'(count), 32'd1);
    pop = 1'b1;
    cyc();
    chk("emptypp_d", 32'(rd_data), 32'h55);
    chk("emptypp_pv", 32'(rd_valid), 32'd1);
    cyc();
    pop = 1'b0;
    chk("pop_empty_v", 32'(rd_valid), 32'd0);
    chk("pop_empty_count", 32'(count), 32'd0);
    chk("pop_empty_hold", 32'(rd_data), 32'h55);

    // Wrap traffic with occupancy oscillating between 3 and 10.
    occ = 0; pushed = 0; popped = 0; up = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (pushed >= 43 && occ == 0) break;
      do_push = (pushed < 43) && (occ < 10) && (up || (i % 3 == 0));
      do_pop  = (occ > 0) && (!up || (i % 3 == 0)) && (occ > 3 || pushed >= 43);
      rx_valid = do_push;
      rx_data  = 8'(pushed + 8'h80);
      pop      = do_pop;
      cyc();
      if (do_push) begin occ++; pushed++; end
      if (do_pop) occ--;
      chk("wrap_v", 32'(rd_valid), 32'(do_pop));
      if (do_pop) begin
        chk("wrap_d", 32'(rd_data), 32'(8'(popped + 8'h80)));
        popped++;
      end
      chk("wrap_count", 32'(count), 32'(occ));
      if (occ >= 10) up = 1'b0;
      if (occ <= 3) up = 1'b1;
    end
    rx_valid = 1'b0; pop = 1'b0;
    chk("wrap_total", 32'(popped), 32'd43);
    chk("wrap_empty", 32'(empty), 32'd1);

    // Asynchronous reset mid-operation with count=5, overflow=1.
    for (int i = 0; i < 17; i++) push_byte(8'(8'h20 + i));
    pop = 1'b1;
    for (int i = 0; i < 11; i++) cyc();
    pop = 1'b0;
    cyc();
    chk("pre_rst_count", 32'(count), 32'd5);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("arst");
    cyc();
    chk("arst_hold_count", 32'(count), 32'd0);
    #2;
    rst = 1'b1;
    cyc();
    chk("arst_rel_rop", 32'(read_op), 32'd1);
    chk("arst_rel_empty", 32'(empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_rx_buffer
